// File: rtl/key_cond_pkg.sv
// key_cond_pkg
//   Shared definitions for the pushbutton conditioner: per-key FSM state
//   encoding, default timing constants and a helper that sizes the
//   stability/hold counter.
package key_cond_pkg;

    typedef enum logic [1:0] {
        REL    = 2'd0,   // released and stable
        P_WAIT = 2'd1,   // press seen, waiting for it to stay stable
        DOWN   = 2'd2,   // pressed and stable, counting towards hold
        R_WAIT = 2'd3    // release seen, waiting for it to stay stable
    } key_state_t;

    localparam int DEF_DEBOUNCE = 20;
    localparam int DEF_HOLD     = 1000;

    // Bits needed to hold values 0..max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// key_debounce_chan
//   One key channel: two-flop synchronizer, debounce FSM with a shared
//   stability/hold counter, and registered level/pulse outputs.
// Ports
//   clk           in   clock (1 kHz tick domain)
//   rst           in   synchronous active-high reset
//   key           in   raw pushbutton, active-low, asynchronous
//   key_down      out  debounced level, 1 = pressed
//   press_pulse   out  one-cycle pulse on accepted press
//   release_pulse out  one-cycle pulse on accepted release
//   hold_pulse    out  one-cycle pulse once per press after HOLD cycles
module key_debounce_chan
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int HOLD     = DEF_HOLD,
    parameter int CNT_W    = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_down,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [1:0]       sync;   // raw (active-low) key, sync[1] is the safe copy
    key_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             s;      // synchronized, active-high "pressed"

    assign s = ~sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync          <= 2'b11;
            state         <= REL;
            cnt           <= '0;
            key_down      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
        end else begin
            sync          <= {sync[0], key};
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
            case (state)
                REL: begin
                    if (s) begin
                        state <= P_WAIT;
                        cnt   <= ONE_C;
                    end
                end
                P_WAIT: begin
                    if (!s) begin
                        state <= REL;
                        cnt   <= '0;
                    end else if (cnt == DEB_C) begin
                        state       <= DOWN;
                        press_pulse <= 1'b1;
                        key_down    <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end
                DOWN: begin
                    if (!s) begin
                        state <= R_WAIT;
                        cnt   <= ONE_C;
                    end else if (cnt < HOLD_C) begin
                        // Saturating count; pulse on the edge it reaches HOLD.
                        cnt        <= cnt + ONE_C;
                        hold_pulse <= (cnt + ONE_C == HOLD_C);
                    end
                end
                R_WAIT: begin
                    if (s) begin
                        // Release bounce: park the counter at saturation so
                        // hold_pulse can never fire again for this press.
                        state <= DOWN;
                        cnt   <= HOLD_C;
                    end else if (cnt == DEB_C) begin
                        state         <= REL;
                        release_pulse <= 1'b1;
                        key_down      <= 1'b0;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end
                default: begin
                    state <= REL;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner
//   Turns raw active-low pushbuttons into debounced levels plus single-cycle
//   press, release and long-hold pulses. Keys are fully independent.
// Ports
//   Clk_1K        in   1 kHz tick clock
//   Reset         in   synchronous active-high reset
//   KEY           in   [N_KEYS] raw pushbuttons, active-low, asynchronous
//   key_down      out  [N_KEYS] debounced level, 1 = pressed
//   press_pulse   out  [N_KEYS] one-cycle pulse on accepted press
//   release_pulse out  [N_KEYS] one-cycle pulse on accepted release
//   hold_pulse    out  [N_KEYS] one-cycle pulse once per press after HOLD
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_KEYS   = 2,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int HOLD     = DEF_HOLD,
    parameter int CNT_W    = 10
) (
    input  logic              Clk_1K,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_down,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] hold_pulse
);

    if (CNT_W < cnt_width(HOLD)) begin : g_cnt_w_err
        $error("key_conditioner: CNT_W too small to count to HOLD");
    end
    if (HOLD <= DEBOUNCE) begin : g_hold_err
        $error("key_conditioner: HOLD must exceed DEBOUNCE");
    end

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE (DEBOUNCE),
            .HOLD     (HOLD),
            .CNT_W    (CNT_W)
        ) u_chan (
            .clk           (Clk_1K),
            .rst           (Reset),
            .key           (KEY[gi]),
            .key_down      (key_down[gi]),
            .press_pulse   (press_pulse[gi]),
            .release_pulse (release_pulse[gi]),
            .hold_pulse    (hold_pulse[gi])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: a per-edge reference model pushes the expected
// outputs into a queue; a monitor on the falling edge pops and compares.
// Directed sections add latency / pulse-count checks on top.
module tb_key_conditioner;
    localparam int NK = 2;
    localparam int DB = 4;
    localparam int HD = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key = '1;
    logic [NK-1:0] key_down, press_pulse, release_pulse, hold_pulse;

    always #5 clk = ~clk;

    key_conditioner #(.N_KEYS(NK), .DEBOUNCE(DB), .HOLD(HD), .CNT_W(10)) dut (
        .Clk_1K        (clk),
        .Reset         (rst),
        .KEY           (key),
        .key_down      (key_down),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .hold_pulse    (hold_pulse)
    );

    typedef struct packed {
        logic [NK-1:0] kd, pp, rp, hp;
    } resp_t;

    resp_t expq[$];
    int checks = 0, failures = 0, edge_cnt = 0;

    // Reference model: a change is accepted once the synchronized key has
    // disagreed with the accepted level for DB+1 consecutive samples; any
    // agreeing sample in between cancels it. Hold counts samples spent
    // pressed after acceptance; a release bounce forfeits the hold.
    bit q1[NK], q2[NK], level[NK], armed[NK];
    int run[NK], held[NK];

    always @(posedge clk) begin : model
        resp_t e;
        bit s;
        e = '0;
        edge_cnt++;
        for (int k = 0; k < NK; k++) begin
            if (rst) begin
                q1[k] = 1; q2[k] = 1; level[k] = 0; run[k] = 0; armed[k] = 0; held[k] = 0;
            end else begin
                s = !q2[k];
                q2[k] = q1[k];
                q1[k] = key[k];
                if (s != level[k]) begin
                    run[k]++;
                    if (run[k] == DB + 1) begin
                        level[k] = s; run[k] = 0; armed[k] = s; held[k] = 0;
                        if (s) e.pp[k] = 1'b1; else e.rp[k] = 1'b1;
                    end
                end else if (run[k] > 0) begin
                    run[k] = 0;
                    if (level[k]) armed[k] = 0;
                end else if (level[k] && armed[k]) begin
                    held[k]++;
                    if (held[k] == HD) begin
                        e.hp[k] = 1'b1; armed[k] = 0;
                    end
                end
            end
            e.kd[k] = level[k];
        end
        expq.push_back(e);
    end

    int npress[NK], nrel[NK], nhold[NK], ndown[NK];
    int lpress[NK], lrel[NK], lhold[NK];

    always @(negedge clk) begin : monitor
        resp_t e, a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {key_down, press_pulse, release_pulse, hold_pulse};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs edge=%0d actual kd=%b pp=%b rp=%b hp=%b expected kd=%b pp=%b rp=%b hp=%b",
                         edge_cnt, a.kd, a.pp, a.rp, a.hp, e.kd, e.pp, e.rp, e.hp);
            end
            for (int k = 0; k < NK; k++) begin
                if (a.pp[k] === 1'b1) begin npress[k]++; lpress[k] = edge_cnt; end
                if (a.rp[k] === 1'b1) begin nrel[k]++;   lrel[k]   = edge_cnt; end
                if (a.hp[k] === 1'b1) begin nhold[k]++;  lhold[k]  = edge_cnt; end
                if (a.kd[k] === 1'b1) ndown[k]++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clr();
        for (int k = 0; k < NK; k++) begin
            npress[k] = 0; nrel[k] = 0; nhold[k] = 0; ndown[k] = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int fall, rise, dea, dur;
        clr();
        // Reset with both keys held: all outputs stay 0.
        rst = 1'b1; key = '0;
        step(3);
        chk("reset_quiet", npress[0] + npress[1] + ndown[0] + ndown[1], 0);
        rst = 1'b0; dea = edge_cnt + 1;
        step(12);
        chk("rst_press0", npress[0], 1);
        chk("rst_press1", npress[1], 1);
        chk("rst_press_lat", lpress[0] - dea, DB + 2);
        chk("rst_press_same", lpress[1], lpress[0]);
        key = '1; step(15);

        // Clean press with long hold, then release.
        clr();
        key[0] = 1'b0; fall = edge_cnt + 1;
        step(20);
        key[0] = 1'b1; rise = edge_cnt + 1;
        step(12);
        chk("clean_press_n", npress[0], 1);
        chk("clean_press_lat", lpress[0] - fall, DB + 2);
        chk("clean_hold_n", nhold[0], 1);
        chk("clean_hold_lat", lhold[0] - lpress[0], HD);
        chk("clean_rel_n", nrel[0], 1);
        chk("clean_rel_lat", lrel[0] - rise, DB + 2);
        chk("clean_other_key", npress[1] + nrel[1] + nhold[1], 0);

        // Bounce shorter than DEBOUNCE: nothing accepted.
        clr();
        key[0] = 1'b0; step(3);
        key[0] = 1'b1; step(1);
        key[0] = 1'b0; step(3);
        key[0] = 1'b1; step(10);
        chk("bounce_press", npress[0], 0);
        chk("bounce_down", ndown[0], 0);
        key[0] = 1'b0; step(5);
        key[0] = 1'b1; step(15);
        chk("bounce_then_press", npress[0], 1);

        // Short press on key 1: no hold, level high 8 cycles.
        clr();
        key[1] = 1'b0; step(8);
        key[1] = 1'b1; step(15);
        chk("short_press", npress[1], 1);
        chk("short_rel", nrel[1], 1);
        chk("short_hold", nhold[1], 0);
        chk("short_down_cycles", ndown[1], 8);

        // Simultaneous press, then reset mid-press with keys still held.
        clr();
        key = '0; step(8);
        chk("simul_n0", npress[0], 1);
        chk("simul_n1", npress[1], 1);
        chk("simul_same", lpress[1], lpress[0]);
        rst = 1'b1; step(2);
        chk("midrst_down_clear", int'(key_down), 0);
        rst = 1'b0; dea = edge_cnt + 1;
        step(10);
        chk("midrst_no_rel", nrel[0] + nrel[1], 0);
        chk("midrst_repress", npress[0], 2);
        chk("midrst_lat", lpress[0] - dea, DB + 2);
        key = '1; step(15);

        // Random bursts: mostly short bounces, some long holds, rare resets.
        repeat (250) begin
            rst = ($urandom_range(0, 40) == 0);
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 1) == 1) key[k] = ~key[k];
            dur = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 25) : $urandom_range(1, 6);
            if (rst) dur = $urandom_range(1, 2);
            step(dur);
        end
        rst = 1'b0; key = '1; step(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
